// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

    localparam int SEG_W = 7;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_e;

    // Active-high {a,b,c,d,e,f,g} patterns for hex digits 0..F.
    localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Producer-side and display-side signals of the scan controller.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    import seg_pkg::*;

    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [SEG_W-1:0]        seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    frame_done;

    modport master (
        output en, load, digits_in, dp_in,
        input  seg_out, dp_out, digit_sel, frame_done
    );

    modport slave (
        input  en, load, digits_in, dp_in,
        output seg_out, dp_out, digit_sel, frame_done
    );

endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational hex nibble to 7-segment pattern lookup.
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blank gaps and frame-synchronous double buffering.
// Optional: define SEG_SCAN_LEADING_ZERO_BLANK_EN to dark leading-zero digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = 4 * NUM_DIGITS;

    scan_state_e           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         shadow_q, shadow_d, active_q, active_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                  en_q;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  fd_q, fd_d;
    logic                  blank_end, boundary, swap;
    logic [3:0]            nib;
    logic [SEG_W-1:0]      dec_seg;

    assign blank_end = (state_q == BLANK) && (cnt_q == CW'(BLANK_CYCLES - 1));
    assign boundary  = blank_end && (idx_q == IW'(NUM_DIGITS - 1));
    // Reload on a frame boundary or on the first enabled edge after a pause.
    assign swap      = bus.en && (!en_q || boundary);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q + CW'(1);
        fd_d        = 1'b0;
        shadow_d    = bus.load ? bus.digits_in : shadow_q;
        shadow_dp_d = bus.load ? bus.dp_in : shadow_dp_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        if (swap) begin
            active_d    = bus.load ? bus.digits_in : shadow_q;
            active_dp_d = bus.load ? bus.dp_in : shadow_dp_q;
        end
        if (!bus.en) begin
            state_d = BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                BLANK: if (blank_end) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    fd_d    = boundary;
                end
                SHOW: if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
                end
            endcase
        end
    end

    always_comb begin
        nib = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) nib = active_d[4*i +: 4];
        end
    end

    hex7seg_decode u_dec (
        .hex_i (nib),
        .seg_o (dec_seg)
    );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  lz_zero;

    // Walk down from the top digit; digit 0 is never examined.
    always_comb begin
        lz_blank = '0;
        lz_zero  = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_zero     = lz_zero && (active_d[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_zero && !active_dp_d[i];
        end
    end
`endif

    always_comb begin
        sel_d = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        if (state_d == SHOW) begin
            sel_d[idx_d] = 1'b1;
            dp_d         = active_dp_d[idx_d];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            seg_d        = lz_blank[idx_d] ? '0 : dec_seg;
`else
            seg_d        = dec_seg;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            en_q        <= 1'b0;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            sel_q       <= '0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            en_q        <= bus.en;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            sel_q       <= sel_d;
            fd_q        <= fd_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.digit_sel  = sel_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

    typedef logic [6:0] seg4_t [4];

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input logic [3:0] sel, input logic [6:0] seg,
                                         input logic dp, input logic fd);
        return {19'b0, sel, seg, dp, fd};
    endfunction

    function automatic logic [31:0] snap();
        return pack(bus.digit_sel, bus.seg_out, bus.dp_out, bus.frame_done);
    endfunction

    // Values are {digit_sel, seg_out, dp_out, frame_done}.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    // Starts one cycle before digit 0 lights; checks 40 cycles. Digit 3 lights on the
    // frame_done edge, so it already shows whatever the swap on that edge delivered.
    task automatic run_frame(input string tag, input seg4_t s, input logic [3:0] dpv,
                             input int load_at, input logic [15:0] ld_val,
                             input logic [3:0] ld_dp);
        int k;
        logic [31:0] exp;
        k = 0;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 10; c++) begin
                tick();
                if (c < 8) exp = pack(4'(1 << d), s[d], dpv[d], (d == 3 && c == 0));
                else       exp = '0;
                chk($sformatf("%s d%0d c%0d", tag, d, c), snap(), exp);
                if (k == load_at + 1) bus.load = 1'b0;
                if (k == load_at) begin
                    bus.load      = 1'b1;
                    bus.digits_in = ld_val;
                    bus.dp_in     = ld_dp;
                end
                k++;
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        tick();
        tick();
        chk("reset", snap(), '0);

        // 1: basic scan of 1234
        rst           = 1'b0;
        bus.en        = 1'b1;
        bus.load      = 1'b1;
        bus.digits_in = 16'h1234;
        tick();
        bus.load = 1'b0;
        chk("t1 first dark", snap(), '0);
        run_frame("t1a", '{7'h33, 7'h79, 7'h6D, 7'h30}, 4'b0000, -1, '0, '0);
        run_frame("t1b", '{7'h33, 7'h79, 7'h6D, 7'h30}, 4'b0000, -1, '0, '0);

        // 2: load D7F0 while digit 1 is lit; held in shadow until frame_done
        run_frame("t2a", '{7'h33, 7'h79, 7'h6D, 7'h3D}, 4'b0000, 15, 16'hD7F0, 4'b0000);
        run_frame("t2b", '{7'h7E, 7'h47, 7'h70, 7'h3D}, 4'b0000, -1, '0, '0);

        // 3: load coincides with the frame_done edge
        run_frame("t3a", '{7'h7E, 7'h47, 7'h70, 7'h7F}, 4'b1000, 29, 16'h89AB, 4'b1010);
        run_frame("t3b", '{7'h1F, 7'h77, 7'h7B, 7'h7F}, 4'b1010, -1, '0, '0);

        // 4: drop en while digit 2 is lit, load while paused, then resume
        repeat (20) tick();
        tick();
        chk("t4 digit2 lit", snap(), pack(4'b0100, 7'h7B, 1'b0, 1'b0));
        bus.en        = 1'b0;
        bus.load      = 1'b1;
        bus.digits_in = 16'h4321;
        bus.dp_in     = 4'b0000;
        tick();
        bus.load = 1'b0;
        chk("t4 dark", snap(), '0);
        for (int i = 0; i < 45; i++) begin
            tick();
            chk($sformatf("t4 idle %0d", i), snap(), '0);
        end
        bus.en = 1'b1;
        tick();
        chk("t4 restart dark", snap(), '0);
        run_frame("t4", '{7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0000, -1, '0, '0);

        // 5: reset pulse during SHOW clears shadow and active
        repeat (4) tick();
        chk("t5 lit before rst", snap(), pack(4'b0001, 7'h30, 1'b0, 1'b0));
        rst = 1'b1;
        tick();
        chk("t5 rst", snap(), '0);
        rst = 1'b0;
        tick();
        chk("t5 restart dark", snap(), '0);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        run_frame("t5", '{7'h7E, 7'h00, 7'h00, 7'h00}, 4'b0000, -1, '0, '0);
`else
        run_frame("t5", '{7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000, -1, '0, '0);
`endif

        // 6: 0050 loaded while paused, taken on the first enabled edge
        bus.en        = 1'b0;
        bus.load      = 1'b1;
        bus.digits_in = 16'h0050;
        tick();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        tick();
        chk("t6 restart dark", snap(), '0);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        run_frame("t6", '{7'h7E, 7'h5B, 7'h00, 7'h00}, 4'b0000, -1, '0, '0);
`else
        run_frame("t6", '{7'h7E, 7'h5B, 7'h7E, 7'h7E}, 4'b0000, -1, '0, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
